// File: rtl/cnn_act_pkg.sv
// Shared types and default sizing for the streaming activation stage.
package cnn_act_pkg;
  localparam int DEF_DW         = 20;
  localparam int DEF_LANES      = 8;
  localparam int DEF_LEAK_SHIFT = 3;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLIP   = 2'd3
  } act_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/cnn_act_lane.sv
// Combinational activation for one signed lane, plus a zero flag for sparsity stats.
module cnn_act_lane
  import cnn_act_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic signed [DW-1:0] x_i,
  input  act_mode_e            mode_i,
  input  logic        [DW-2:0] clip_i,
  output logic signed [DW-1:0] y_o,
  output logic                 is_zero_o
);
  always_comb begin
    y_o = x_i;
    case (mode_i)
      ACT_BYPASS: y_o = x_i;
      ACT_RELU:   y_o = x_i[DW-1] ? '0 : x_i;
      // arithmetic shift floors, so small negatives settle at -1, never 0
      ACT_LEAKY:  y_o = x_i[DW-1] ? (x_i >>> LEAK_SHIFT) : x_i;
      ACT_CLIP: begin
        if (x_i[DW-1])               y_o = '0;
        else if (x_i[DW-2:0] > clip_i) y_o = {1'b0, clip_i};
        else                         y_o = x_i;
      end
      default: y_o = x_i;
    endcase
  end

  assign is_zero_o = (y_o == '0);
endmodule

// File: rtl/cnn_act_stream.sv
// Streaming per-frame activation: frame-latched config, 2-stage stallable pipe, zero counter.
module cnn_act_stream
  import cnn_act_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int LANES      = DEF_LANES,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           cfg_mode,
  input  logic [DW-2:0]        cfg_clip,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data [0:LANES-1],
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_data [0:LANES-1],
  output logic                 m_last,
  output logic                 stat_valid,
  output logic [CNT_W-1:0]     stat_zeros
);
  localparam int STAGES = 2;
  localparam int ZC_W   = $clog2(LANES + 1);

  state_e              state_q, state_d;
  act_mode_e           mode_q, mode_d;
  logic [DW-2:0]       clip_q, clip_d;
  logic [STAGES:1]     vld_pipe_q;
  logic signed [DW-1:0] s1_data_q [0:LANES-1];
  logic                s1_last_q;
  act_mode_e           s1_mode_q;
  logic [DW-2:0]       s1_clip_q;
  logic signed [DW-1:0] m_data_q [0:LANES-1];
  logic                m_last_q;
  logic [ZC_W-1:0]     m_zc_q, zc;
  logic signed [DW-1:0] lane_y [0:LANES-1];
  logic [LANES-1:0]    lane_zero;
  logic [CNT_W-1:0]    cnt_q, cnt_sat;
  logic [CNT_W:0]      cnt_sum;
  logic                stat_valid_q;
  logic [CNT_W-1:0]    stat_zeros_q;
  logic                en, accept, m_hs;

  assign en      = !vld_pipe_q[STAGES] | m_ready;
  assign accept  = s_valid & en;
  assign m_hs    = vld_pipe_q[STAGES] & m_ready;
  assign s_ready = en;

  // mode_d/clip_d already carry the fresh config on a frame's first beat
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    clip_d  = clip_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        mode_d = act_mode_e'(cfg_mode);
        clip_d = cfg_clip;
        if (!s_last) state_d = ST_RUN;
      end
      ST_RUN: if (accept && s_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= ACT_BYPASS;
      clip_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      clip_q  <= clip_d;
    end
  end

  genvar g;
  for (g = 0; g < LANES; g++) begin : g_lane
    cnn_act_lane #(.DW(DW), .LEAK_SHIFT(LEAK_SHIFT)) u_lane (
      .x_i      (s1_data_q[g]),
      .mode_i   (s1_mode_q),
      .clip_i   (s1_clip_q),
      .y_o      (lane_y[g]),
      .is_zero_o(lane_zero[g])
    );
  end

  always_comb begin
    zc = '0;
    for (int i = 0; i < LANES; i++) zc = zc + ZC_W'(lane_zero[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= ACT_BYPASS;
      s1_clip_q  <= '0;
      m_last_q   <= 1'b0;
      m_zc_q     <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_data_q[i] <= '0;
        m_data_q[i]  <= '0;
      end
    end else if (en) begin
      vld_pipe_q <= {vld_pipe_q[1], s_valid};
      s1_last_q  <= s_last;
      s1_mode_q  <= mode_d;
      s1_clip_q  <= clip_d;
      m_last_q   <= s1_last_q;
      m_zc_q     <= zc;
      for (int i = 0; i < LANES; i++) begin
        s1_data_q[i] <= s_data[i];
        m_data_q[i]  <= lane_y[i];
      end
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(m_zc_q);
  assign cnt_sat = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      stat_valid_q <= 1'b0;
      stat_zeros_q <= '0;
    end else begin
      stat_valid_q <= 1'b0;
      if (m_hs) begin
        if (m_last_q) begin
          stat_zeros_q <= cnt_sat;
          stat_valid_q <= 1'b1;
          cnt_q        <= '0;
        end else begin
          cnt_q <= cnt_sat;
        end
      end
    end
  end

  assign m_valid    = vld_pipe_q[STAGES];
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign stat_valid = stat_valid_q;
  assign stat_zeros = stat_zeros_q;
endmodule

// File: tb/tb_cnn_act_stream.sv
// Directed bench for cnn_act_stream: modes, frame config latching, stalls, reset, saturation.
module tb_cnn_act_stream;
  localparam int DW = 20;
  localparam int LANES = 8;

  logic clk, rst_n;
  logic [1:0] cfg_mode;
  logic [DW-2:0] cfg_clip;
  logic s_valid, s_ready, s_last, m_valid, m_ready, m_last, stat_valid;
  logic signed [DW-1:0] s_data [0:LANES-1];
  logic signed [DW-1:0] m_data [0:LANES-1];
  logic [15:0] stat_zeros;
  logic s_ready4, m_valid4, m_last4, stat_valid4;
  logic signed [DW-1:0] m_data4 [0:LANES-1];
  logic [3:0] stat_zeros4;

  int checks = 0;
  int failures = 0;
  int in_v [8];
  int exp_v [8];

  cnn_act_stream #(.DW(DW), .LANES(LANES), .LEAK_SHIFT(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_clip(cfg_clip),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .stat_valid(stat_valid), .stat_zeros(stat_zeros));

  cnn_act_stream #(.DW(DW), .LANES(LANES), .LEAK_SHIFT(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_clip(cfg_clip),
    .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .m_last(m_last4),
    .stat_valid(stat_valid4), .stat_zeros(stat_zeros4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    for (int j = 0; j < LANES; j++) s_data[j] = in_v[j][DW-1:0];
  endtask

  function automatic int gen(input int i, input int j);
    return ((i * 8 + j) * 7919) % 2001 - 1000;
  endfunction

  // Sends nb identical beats of in_v (config may change after beat 0) and checks
  // every output cycle, the latency, the last flag and the end-of-frame statistic.
  task automatic frame(input string tag, input int nb, input int mode0, input int clip0,
                       input int mode1, input int clip1, input int zeros);
    int z4;
    z4 = (zeros > 15) ? 15 : zeros;
    for (int k = 0; k < nb + 4; k++) begin
      if (k < nb) begin
        cfg_mode = (k == 0) ? mode0[1:0] : mode1[1:0];
        cfg_clip = (k == 0) ? clip0[DW-2:0] : clip1[DW-2:0];
        s_valid = 1'b1;
        s_last = (k == nb - 1);
        load();
      end else begin
        s_valid = 1'b0;
        s_last = 1'b0;
      end
      if (k >= 2 && k - 2 < nb) begin
        chk({tag, "_mvalid"}, m_valid, 1);
        chk({tag, "_mlast"}, m_last, (k - 2 == nb - 1));
        for (int j = 0; j < LANES; j++) chk({tag, "_data"}, m_data[j], exp_v[j]);
      end else begin
        chk({tag, "_mvalid_idle"}, m_valid, 0);
      end
      chk({tag, "_statv"}, stat_valid, (k == nb + 2));
      if (k == nb + 2) begin
        chk({tag, "_zeros"}, stat_zeros, zeros);
        chk({tag, "_zeros4"}, stat_zeros4, z4);
      end
      step();
    end
  endtask

  initial begin
    int src, rcv, pulses, zexp, settle, held, ok, v, y;
    logic signed [DW-1:0] saved [0:LANES-1];
    logic saved_last;
    rst_n = 1'b0; cfg_mode = 2'd0; cfg_clip = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    for (int j = 0; j < LANES; j++) s_data[j] = '0;
    #12;
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mlast", m_last, 0);
    chk("rst_mdata0", m_data[0], 0);
    chk("rst_statv", stat_valid, 0);
    chk("rst_zeros", stat_zeros, 0);
    chk("rst_sready", s_ready, 1);
    rst_n = 1'b1;
    step();

    in_v = '{-5, 0, 7, -1, 100, -524288, 524287, 3};
    exp_v = '{0, 0, 7, 0, 100, 0, 524287, 3};
    frame("relu", 3, 1, 0, 1, 0, 12);
    chk("relu_zeros_hold", stat_zeros, 12);

    in_v = '{-16, -1, -9, 8, 0, 0, 0, 0};
    exp_v = '{-2, -1, -2, 8, 0, 0, 0, 0};
    frame("leaky", 1, 2, 0, 2, 0, 4);

    in_v = '{-16, -1, -9, 8, -524288, 524287, 5, -7};
    exp_v = in_v;
    frame("bypass", 1, 0, 0, 0, 0, 0);

    in_v = '{49, 50, 51, -3, 0, 0, 0, 0};
    exp_v = '{49, 50, 50, 0, 0, 0, 0, 0};
    frame("clip50", 2, 3, 50, 0, 10, 10);
    exp_v = '{10, 10, 10, 0, 0, 0, 0, 0};
    frame("clip10", 1, 3, 10, 3, 10, 5);

    in_v = '{-3, -3, -3, -3, -3, -3, -3, -3};
    exp_v = '{0, 0, 0, 0, 0, 0, 0, 0};
    frame("single_neg", 1, 1, 0, 1, 0, 8);

    in_v = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_v = in_v;
    frame("sat", 3, 0, 0, 0, 0, 24);

    // 100-beat ReLU frame under random backpressure
    src = 0; rcv = 0; pulses = 0; zexp = 0; settle = 0; held = 0; saved_last = 1'b0;
    for (int j = 0; j < LANES; j++) saved[j] = '0;
    cfg_mode = 2'd1; cfg_clip = '0;
    for (int j = 0; j < LANES; j++) in_v[j] = gen(0, j);
    load();
    s_valid = 1'b1; s_last = 1'b0; m_ready = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 3000 && settle < 4; cyc++) begin
      @(negedge clk);
      if (m_valid) begin
        if (held != 0) begin
          ok = 1;
          for (int j = 0; j < LANES; j++) if (m_data[j] !== saved[j]) ok = 0;
          if (m_last !== saved_last) ok = 0;
          chk("rnd_stable", ok, 1);
        end
        if (m_ready) begin
          ok = 1;
          for (int j = 0; j < LANES; j++) begin
            v = gen(rcv, j);
            y = (v < 0) ? 0 : v;
            if (y == 0) zexp++;
            if (int'(m_data[j]) != y) ok = 0;
          end
          chk("rnd_data", ok, 1);
          chk("rnd_last", m_last, (rcv == 99));
          rcv++;
          held = 0;
        end else begin
          held = 1;
          saved = m_data;
          saved_last = m_last;
        end
      end
      if (stat_valid) begin
        pulses++;
        chk("rnd_zeros", stat_zeros, zexp);
      end
      if (s_valid && s_ready) src++;
      @(posedge clk);
      #1;
      s_valid = (src < 100);
      s_last = (src == 99);
      for (int j = 0; j < LANES; j++) in_v[j] = gen(src, j);
      load();
      m_ready = 1'($urandom_range(0, 1));
      if (rcv == 100) settle++;
    end
    chk("rnd_sent", src, 100);
    chk("rnd_received", rcv, 100);
    chk("rnd_pulses", pulses, 1);
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    step(); step();

    // reset with two beats in flight
    in_v = '{-1, -1, -1, -1, -1, -1, -1, -1};
    cfg_mode = 2'd1; s_valid = 1'b1; s_last = 1'b0; load();
    step();
    step();
    chk("inflight_mvalid", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mvalid", m_valid, 0);
    chk("async_rst_sready", s_ready, 1);
    s_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("post_rst_statv", stat_valid, 0);
    chk("post_rst_zeros", stat_zeros, 0);
    step();
    chk("post_rst_statv2", stat_valid, 0);
    in_v = '{1, 2, 3, 4, 5, 6, 0, -7};
    exp_v = '{1, 2, 3, 4, 5, 6, 0, 0};
    frame("after_rst", 1, 1, 0, 1, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
